// File: rtl/parking_occupancy_ctrl_if.sv
// ---------------------------------------------------------------------------
// parking_occupancy_ctrl_if : sensor/status bundle for the occupancy controller
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface parking_occupancy_ctrl_if #(
  parameter int CAPACITY  = 3,
  parameter int NUM_HOURS = 8,
  parameter int ENT_W     = 4
) ();
  localparam int CNT_W  = $clog2(CAPACITY + 1);
  localparam int HOUR_W = $clog2(NUM_HOURS);

  logic              car_enter;
  logic              car_exit;
  logic              incr_hour;
  logic [CNT_W-1:0]  occupancy;
  logic              is_full;
  logic              is_empty;
  logic              entry_rejected;
  logic [HOUR_W-1:0] hour;
  logic              day_done;
  logic              rush_valid;
  logic [HOUR_W-1:0] rush_start;
  logic [HOUR_W-1:0] rush_end;
  logic [HOUR_W-1:0] rd_addr;
  logic [ENT_W-1:0]  rd_entries;

  modport master (
    output car_enter, car_exit, incr_hour, rd_addr,
    input  occupancy, is_full, is_empty, entry_rejected, hour, day_done,
           rush_valid, rush_start, rush_end, rd_entries
  );

  modport slave (
    input  car_enter, car_exit, incr_hour, rd_addr,
    output occupancy, is_full, is_empty, entry_rejected, hour, day_done,
           rush_valid, rush_start, rush_end, rd_entries
  );
endinterface

`default_nettype wire

// File: rtl/parking_occupancy_ctrl.sv
// ---------------------------------------------------------------------------
// parking_occupancy_ctrl : car-park occupancy, hour, rush and per-hour history
// Optional history store enabled by `define PARKING_HISTORY_EN
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module parking_occupancy_ctrl #(
  parameter int CAPACITY  = 3,
  parameter int NUM_HOURS = 8,
  parameter int ENT_W     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  parking_occupancy_ctrl_if.slave  bus
);
  localparam int CNT_W  = $clog2(CAPACITY + 1);
  localparam int HOUR_W = $clog2(NUM_HOURS);

  localparam logic [CNT_W-1:0]  c_CAP       = CNT_W'(CAPACITY);
  localparam logic [HOUR_W-1:0] c_LAST_HOUR = HOUR_W'(NUM_HOURS - 1);

  typedef enum logic [0:0] {HR_COUNTING = 1'b0, HR_DAY_DONE = 1'b1} hour_state_t;
  typedef enum logic [1:0] {RS_IDLE = 2'd0, RS_IN_RUSH = 2'd1, RS_CAPTURED = 2'd2} rush_state_t;

  logic              r_prev_ent, r_prev_ext, r_prev_hr;
  logic              r_ent_ev, r_ext_ev, r_hr_ev;
  logic [CNT_W-1:0]  r_occ;
  logic              r_entry_rejected;
  logic [HOUR_W-1:0] r_hour;
  logic              r_day_done;
  hour_state_t       r_hour_state;
  rush_state_t       r_rush_state;
  logic              r_rush_valid;
  logic [HOUR_W-1:0] r_rush_start;
  logic [HOUR_W-1:0] r_rush_end;

  logic              w_full, w_empty;
  logic [CNT_W-1:0]  w_occ_nxt;
  logic              w_accept, w_reject;

  assign w_full  = (r_occ == c_CAP);
  assign w_empty = (r_occ == '0);

  // Edges are registered once before they touch the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_ent <= 1'b0;
      r_prev_ext <= 1'b0;
      r_prev_hr  <= 1'b0;
      r_ent_ev   <= 1'b0;
      r_ext_ev   <= 1'b0;
      r_hr_ev    <= 1'b0;
    end else begin
      r_prev_ent <= bus.car_enter;
      r_prev_ext <= bus.car_exit;
      r_prev_hr  <= bus.incr_hour;
      r_ent_ev   <= bus.car_enter & ~r_prev_ent;
      r_ext_ev   <= bus.car_exit  & ~r_prev_ext;
      r_hr_ev    <= bus.incr_hour & ~r_prev_hr;
    end
  end

  always_comb begin
    w_occ_nxt = r_occ;
    w_accept  = 1'b0;
    w_reject  = 1'b0;
    case ({r_ent_ev, r_ext_ev})
      2'b10: begin
        if (w_full) begin
          w_reject = 1'b1;
        end else begin
          w_occ_nxt = r_occ + 1'b1;
          w_accept  = 1'b1;
        end
      end
      2'b01: begin
        if (!w_empty) w_occ_nxt = r_occ - 1'b1;
      end
      2'b11:   w_accept = 1'b1;
      default: w_occ_nxt = r_occ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ            <= '0;
      r_entry_rejected <= 1'b0;
    end else begin
      r_occ            <= w_occ_nxt;
      r_entry_rejected <= w_reject;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hour_state <= HR_COUNTING;
      r_hour       <= '0;
      r_day_done   <= 1'b0;
    end else begin
      case (r_hour_state)
        HR_COUNTING: begin
          if (r_hr_ev) begin
            if (r_hour == c_LAST_HOUR) begin
              r_hour_state <= HR_DAY_DONE;
              r_day_done   <= 1'b1;
            end else begin
              r_hour <= r_hour + 1'b1;
            end
          end
        end
        HR_DAY_DONE: r_day_done <= 1'b1;
        default:     r_hour_state <= HR_COUNTING;
      endcase
    end
  end

  // Rush edges are qualified on a change of occupancy, so a swap at full does not re-trigger.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rush_state <= RS_IDLE;
      r_rush_valid <= 1'b0;
      r_rush_start <= '0;
      r_rush_end   <= '0;
    end else begin
      case (r_rush_state)
        RS_IDLE: begin
          if ((w_occ_nxt == c_CAP) && !w_full) begin
            r_rush_state <= RS_IN_RUSH;
            r_rush_start <= r_hour;
          end
        end
        RS_IN_RUSH: begin
          if ((w_occ_nxt == '0) && !w_empty) begin
            r_rush_state <= RS_CAPTURED;
            r_rush_end   <= r_hour;
            r_rush_valid <= 1'b1;
          end
        end
        RS_CAPTURED: r_rush_valid <= 1'b1;
        default:     r_rush_state <= RS_IDLE;
      endcase
    end
  end

`ifdef PARKING_HISTORY_EN
  localparam logic [HOUR_W:0] c_NUM_HOURS_EXT = (HOUR_W + 1)'(NUM_HOURS);

  logic [ENT_W-1:0] r_hist [NUM_HOURS];
  logic             w_rd_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_HOURS; i++) r_hist[i] <= '0;
    end else if (w_accept && (r_hist[r_hour] != '1)) begin
      r_hist[r_hour] <= r_hist[r_hour] + 1'b1;
    end
  end

  assign w_rd_ok        = ({1'b0, bus.rd_addr} < c_NUM_HOURS_EXT);
  assign bus.rd_entries = w_rd_ok ? r_hist[bus.rd_addr] : '0;
`else
  assign bus.rd_entries = '0;
`endif

  assign bus.occupancy      = r_occ;
  assign bus.is_full        = w_full;
  assign bus.is_empty       = w_empty;
  assign bus.entry_rejected = r_entry_rejected;
  assign bus.hour           = r_hour;
  assign bus.day_done       = r_day_done;
  assign bus.rush_valid     = r_rush_valid;
  assign bus.rush_start     = r_rush_start;
  assign bus.rush_end       = r_rush_end;

endmodule

`default_nettype wire
